branch_target_buffer: RTL and testbench

//  Fetch-side producer of the BranchPredict record consumed by the decode-stage hazard check.

---
 rtl/branch_target_buffer_pkg.sv | 37 +++
 rtl/branch_target_buffer_counter_update.sv | 26 ++
 rtl/branch_target_buffer.sv | 100 ++++++++++
 tb/tb_branch_target_buffer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/branch_target_buffer_pkg.sv
// Shared types for the fetch-side branch target buffer.
// Holds PC width, BranchPredict record, BTB counter/entry types.
package branch_target_buffer_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef logic [ADDR_WIDTH-1:0] PC;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef struct packed {
    logic isNextPcPredicted;
    logic isBranchTakenPredicted;
    PC    predictedNextPc;
  } BranchPredict;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } BtbCounter;

  localparam int BTB_ENTRY_NUM = 64;
  localparam int BTB_INDEX_WIDTH = $clog2(BTB_ENTRY_NUM);
  localparam int BTB_TAG_WIDTH =
    ADDR_WIDTH - BTB_INDEX_WIDTH - 2;

  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_WIDTH-1:0] tag;
    logic [ADDR_WIDTH-3:0]    target;
    BtbCounter                ctr;
  } BtbEntry;

endpackage

// File: rtl/branch_target_buffer_counter_update.sv
// Next-state function of a BTB 2-bit saturating counter.
// Ports: ctr/taken/hit in, next out; a miss allocates at WT.
module btb_counter_update
  import branch_target_buffer_pkg::*;
(
  input  BtbCounter ctr,
  input  logic      taken,
  input  logic      hit,
  output BtbCounter next
);

  always_comb begin
    next = WT;
    unique case (1'b1)
      !hit: next = WT;
      hit && taken:
        next = (ctr == ST) ? ST :
               BtbCounter'(ctr + 2'd1);
      hit && !taken:
        next = (ctr == SNT) ? SNT :
               BtbCounter'(ctr - 2'd1);
      default: next = WT;
    endcase
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational lookup, registered training.
// Ports: clk, rstN, fetchPc, branchPredict, update{En,Pc,Taken,Target}.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int ENTRY_NUM = BTB_ENTRY_NUM
) (
  input  logic         clk,
  input  logic         rstN,
  input  PC            fetchPc,
  output BranchPredict branchPredict,
  input  logic         updateEn,
  input  PC            updatePc,
  input  logic         updateTaken,
  input  PC            updateTarget
);

  localparam int INDEX_WIDTH = $clog2(ENTRY_NUM);
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

  typedef logic [INDEX_WIDTH-1:0] idx_t;
  typedef logic [TAG_WIDTH-1:0]   tag_t;

  typedef struct packed {
    tag_t                  tag;
    logic [ADDR_WIDTH-3:0] target;
    BtbCounter             ctr;
  } slot_t;

  logic [ENTRY_NUM-1:0] valid;
  slot_t                mem [ENTRY_NUM];

  idx_t      l_idx, u_idx;
  tag_t      l_tag, u_tag;
  slot_t     l_slot, u_slot;
  logic      l_hit, u_hit;
  logic      l_taken;
  BtbCounter u_ctr;
  PC         seq_pc;

  assign l_idx  = fetchPc[INDEX_WIDTH+1:2];
  assign l_tag  = fetchPc[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign u_idx  = updatePc[INDEX_WIDTH+1:2];
  assign u_tag  = updatePc[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign l_slot = mem[l_idx];
  assign u_slot = mem[u_idx];
  assign l_hit  = valid[l_idx] && (l_slot.tag == l_tag);
  assign u_hit  = valid[u_idx] && (u_slot.tag == u_tag);
  assign l_taken = l_hit && l_slot.ctr[1];
  assign seq_pc  = fetchPc + PC'(4);

  btb_counter_update u_ctr_upd (
    .ctr   (u_slot.ctr),
    .taken (updateTaken),
    .hit   (u_hit),
    .next  (u_ctr)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      valid <= '0;
    end else if (updateEn && !u_hit && updateTaken) begin
      valid[u_idx] <= 1'b1;
    end
  end

  // Payload has no reset; the rstN gate only keeps an
  // update coinciding with reset from touching it.
  always_ff @(posedge clk) begin
    if (rstN && updateEn) begin
      if (u_hit) begin
        mem[u_idx].ctr <= u_ctr;
        if (updateTaken)
          mem[u_idx].target <= updateTarget[ADDR_WIDTH-1:2];
      end else if (updateTaken) begin
        mem[u_idx].tag    <= u_tag;
        mem[u_idx].target <= updateTarget[ADDR_WIDTH-1:2];
        mem[u_idx].ctr    <= u_ctr;
      end
    end
  end

  always_comb begin
`ifdef NOT_USE_BTB
    branchPredict.isNextPcPredicted = FALSE;
    branchPredict.isBranchTakenPredicted = l_taken;
    branchPredict.predictedNextPc = seq_pc;
`else
    branchPredict.isNextPcPredicted = l_hit;
    branchPredict.isBranchTakenPredicted = l_taken;
    branchPredict.predictedNextPc =
      l_taken ? {l_slot.target, 2'b00} : seq_pc;
`endif
  end

  logic unused_bits;
  assign unused_bits = ^{fetchPc[1:0], updatePc[1:0],
                         updateTarget[1:0]};

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer.
// Drives lookups/updates and compares against hand values.
module tb_branch_target_buffer;
  import branch_target_buffer_pkg::*;

  logic         clk = 1'b0;
  logic         rstN;
  PC            fetchPc;
  BranchPredict branchPredict;
  logic         updateEn;
  PC            updatePc;
  logic         updateTaken;
  PC            updateTarget;

  int n_tests = 0;
  int n_fail  = 0;

  branch_target_buffer dut (
    .clk           (clk),
    .rstN          (rstN),
    .fetchPc       (fetchPc),
    .branchPredict (branchPredict),
    .updateEn      (updateEn),
    .updatePc      (updatePc),
    .updateTaken   (updateTaken),
    .updateTarget  (updateTarget)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic train(input PC pc, input logic tk,
                       input PC tgt);
    updateEn = 1'b1;
    updatePc = pc;
    updateTaken = tk;
    updateTarget = tgt;
    tick();
    updateEn = 1'b0;
  endtask

  task automatic look(input string tag, input PC pc,
                      input logic hit, input logic tk,
                      input PC npc);
    fetchPc = pc;
    #1;
    check({tag, ".hit"}, 32'(branchPredict.isNextPcPredicted),
          32'(hit));
    check({tag, ".tkn"},
          32'(branchPredict.isBranchTakenPredicted), 32'(tk));
    check({tag, ".npc"}, branchPredict.predictedNextPc, npc);
  endtask

  initial begin
    rstN = 1'b0;
    fetchPc = '0;
    updateEn = 1'b0;
    updatePc = '0;
    updateTaken = 1'b0;
    updateTarget = '0;
    tick();
    look("rst_hold", 32'h0, 1'b0, 1'b0, 32'h4);
    tick();
    #2 rstN = 1'b1;
    tick();

    for (int a = 0; a <= 32'h100; a += 4) begin
      fetchPc = PC'(a);
      #1;
      check("sweep.hit",
            32'(branchPredict.isNextPcPredicted), 32'h0);
      check("sweep.npc", branchPredict.predictedNextPc,
            PC'(a + 4));
    end

    train(32'h100, 1'b1, 32'h200);
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);

    train(32'h100, 1'b0, 32'h0);
    look("nt1", 32'h100, 1'b1, 1'b0, 32'h104);
    train(32'h100, 1'b0, 32'h0);
    look("nt2", 32'h100, 1'b1, 1'b0, 32'h104);
    train(32'h100, 1'b0, 32'h0);
    look("nt3", 32'h100, 1'b1, 1'b0, 32'h104);
    train(32'h100, 1'b1, 32'h200);
    look("t1", 32'h100, 1'b1, 1'b0, 32'h104);
    train(32'h100, 1'b1, 32'h200);
    look("t2", 32'h100, 1'b1, 1'b1, 32'h200);
    train(32'h100, 1'b1, 32'h200);
    look("t3", 32'h100, 1'b1, 1'b1, 32'h200);
    train(32'h100, 1'b0, 32'h0);
    look("st_nt", 32'h100, 1'b1, 1'b1, 32'h200);

    train(32'h200, 1'b1, 32'h300);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
    look("alias_new", 32'h200, 1'b1, 1'b1, 32'h300);
    train(32'h300, 1'b0, 32'h0);
    look("nt_miss_a", 32'h300, 1'b0, 1'b0, 32'h304);
    look("nt_miss_b", 32'h200, 1'b1, 1'b1, 32'h300);

    train(32'h100, 1'b1, 32'h200);
    updateEn = 1'b1;
    updatePc = 32'h100;
    updateTaken = 1'b1;
    updateTarget = 32'h400;
    look("same_cyc", 32'h100, 1'b1, 1'b1, 32'h200);
    tick();
    updateEn = 1'b0;
    look("after_upd", 32'h100, 1'b1, 1'b1, 32'h400);

    look("pre_rst", 32'h100, 1'b1, 1'b1, 32'h400);
    updateEn = 1'b1;
    updatePc = 32'h504;
    updateTaken = 1'b1;
    updateTarget = 32'h600;
    #1 rstN = 1'b0;
    look("async_rst", 32'h100, 1'b0, 1'b0, 32'h104);
    tick();
    updateEn = 1'b0;
    #2 rstN = 1'b1;
    tick();
    look("post_a", 32'h100, 1'b0, 1'b0, 32'h104);
    look("post_b", 32'h504, 1'b0, 1'b0, 32'h508);
    look("post_c", 32'h200, 1'b0, 1'b0, 32'h204);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
